// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide unit owning the HI/LO pair: 32-cycle shift-add multiply,
// 32-cycle restoring divide, with sign fix-up in a final cycle.
module muldiv_sequencer #(
    parameter logic [31:0] DBZ_LO      = 32'hFFFF_FFFF,
    parameter bit          DBZ_HI_PASS = 1'b1
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iStart,
    input  logic [2:0]  iOp,
    input  logic [31:0] iA,
    input  logic [31:0] iB,
    input  logic        iReadReq,
    output logic        oBusy,
    output logic        oDone,
    output logic        oDivByZero,
    output logic        oStall,
    output logic [31:0] oHI,
    output logic [31:0] oLO
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    logic [1:0]  stateQ, stateD;
    logic [4:0]  countQ, countD;
    logic        isDivQ, isDivD;
    logic        signAQ, signAD;
    logic        signBQ, signBD;
    logic [31:0] opQ, opD;
    logic [63:0] accQ, accD;
    logic [31:0] remQ, remD;
    logic [31:0] hiQ, hiD;
    logic [31:0] loQ, loD;
    logic        doneQ, doneD;
    logic        dbzQ, dbzD;

    logic        isSignedOp;
    logic [31:0] absA, absB;
    logic [32:0] mulSum;
    logic [32:0] divShift;
    logic        divFits;
    logic [63:0] product;
    logic [31:0] quotient, remainder;

    assign isSignedOp = (iOp == OP_MULT) || (iOp == OP_DIV);
    assign absA       = (isSignedOp && iA[31]) ? (32'd0 - iA) : iA;
    assign absB       = (isSignedOp && iB[31]) ? (32'd0 - iB) : iB;

    // Multiply: multiplier sits in accQ[31:0] and shifts out LSB first as the product grows on top.
    assign mulSum = {1'b0, accQ[63:32]} + (accQ[0] ? {1'b0, opQ} : 33'd0);

    // Divide: dividend shifts out of accQ[31:0] MSB first while quotient bits shift in.
    assign divShift = {remQ, accQ[31]};
    assign divFits  = divShift >= {1'b0, opQ};

    assign product   = (signAQ ^ signBQ) ? (64'd0 - accQ) : accQ;
    assign quotient  = (signAQ ^ signBQ) ? (32'd0 - accQ[31:0]) : accQ[31:0];
    assign remainder = signAQ ? (32'd0 - remQ) : remQ;

    always_comb begin
        stateD = stateQ;
        countD = countQ;
        isDivD = isDivQ;
        signAD = signAQ;
        signBD = signBQ;
        opD    = opQ;
        accD   = accQ;
        remD   = remQ;
        hiD    = hiQ;
        loD    = loQ;
        doneD  = 1'b0;
        dbzD   = 1'b0;
        case (stateQ)
            IDLE: begin
                if (iStart) begin
                    case (iOp)
                        OP_MTHI: hiD = iA;
                        OP_MTLO: loD = iA;
                        OP_MULT, OP_MULTU: begin
                            opD    = absA;
                            accD   = {32'd0, absB};
                            signAD = isSignedOp & iA[31];
                            signBD = isSignedOp & iB[31];
                            isDivD = 1'b0;
                            countD = 5'd0;
                            stateD = CALC;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (iB == 32'd0) begin
                                loD   = DBZ_LO;
                                hiD   = DBZ_HI_PASS ? iA : 32'd0;
                                doneD = 1'b1;
                                dbzD  = 1'b1;
                            end else begin
                                opD    = absB;
                                accD   = {32'd0, absA};
                                remD   = 32'd0;
                                signAD = isSignedOp & iA[31];
                                signBD = isSignedOp & iB[31];
                                isDivD = 1'b1;
                                countD = 5'd0;
                                stateD = CALC;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (isDivQ) begin
                    remD = divFits ? (divShift[31:0] - opQ) : divShift[31:0];
                    accD = {accQ[63:32], accQ[30:0], divFits};
                end else begin
                    accD = {mulSum, accQ[31:1]};
                end
                countD = countQ + 5'd1;
                if (countQ == 5'd31) stateD = FIX;
            end
            FIX: begin
                if (isDivQ) begin
                    hiD = remainder;
                    loD = quotient;
                end else begin
                    hiD = product[63:32];
                    loD = product[31:0];
                end
                doneD  = 1'b1;
                stateD = IDLE;
            end
            default: stateD = IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            stateQ <= IDLE;
            countQ <= 5'd0;
            isDivQ <= 1'b0;
            signAQ <= 1'b0;
            signBQ <= 1'b0;
            opQ    <= 32'd0;
            accQ   <= 64'd0;
            remQ   <= 32'd0;
            hiQ    <= 32'd0;
            loQ    <= 32'd0;
            doneQ  <= 1'b0;
            dbzQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            countQ <= countD;
            isDivQ <= isDivD;
            signAQ <= signAD;
            signBQ <= signBD;
            opQ    <= opD;
            accQ   <= accD;
            remQ   <= remD;
            hiQ    <= hiD;
            loQ    <= loD;
            doneQ  <= doneD;
            dbzQ   <= dbzD;
        end
    end

    assign oBusy      = (stateQ != IDLE);
    assign oDone      = doneQ;
    assign oDivByZero = dbzQ;
    assign oStall     = iReadReq & oBusy;
    assign oHI        = hiQ;
    assign oLO        = loQ;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: expected HI/LO come from plain 64-bit
// arithmetic and are checked by a monitor whenever oDone pulses.
module tb_muldiv_sequencer;

    logic        iCLK = 1'b0;
    logic        iRST;
    logic        iStart;
    logic [2:0]  iOp;
    logic [31:0] iA, iB;
    logic        iReadReq;
    logic        oBusy, oDone, oDivByZero, oStall;
    logic [31:0] oHI, oLO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
    } expT;

    expT         sbQ[$];
    int          checkCnt = 0;
    int          passCnt  = 0;
    logic [31:0] curHi = 32'd0;
    logic [31:0] curLo = 32'd0;

    muldiv_sequencer dut (
        .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
        .iReadReq(iReadReq), .oBusy(oBusy), .oDone(oDone), .oDivByZero(oDivByZero),
        .oStall(oStall), .oHI(oHI), .oLO(oLO)
    );

    always #5 iCLK = ~iCLK;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checkCnt++;
        if (act === exp) passCnt++;
        else $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic failTimeout(input string name);
        checkCnt++;
        $display("[TB] FAIL %s: timed out waiting on DUT", name);
    endtask

    // Reference: signed ops via sign-extended 64-bit arithmetic, which truncates toward zero
    function automatic expT computeExpected(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        expT         e;
        longint      sp, sq, sr;
        logic [63:0] up;
        e.dbz = 1'b0;
        e.hi  = 32'd0;
        e.lo  = 32'd0;
        case (op)
            3'd0: begin
                sp = longint'($signed(a)) * longint'($signed(b));
                up = 64'(sp);
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            3'd1: begin
                up = {32'd0, a} * {32'd0, b};
                e.hi = up[63:32];
                e.lo = up[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                    e.lo  = 32'hFFFF_FFFF;
                    e.hi  = a;
                end else if (op == 3'd2) begin
                    sq = longint'($signed(a)) / longint'($signed(b));
                    sr = longint'($signed(a)) % longint'($signed(b));
                    e.lo = 32'(sq);
                    e.hi = 32'(sr);
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every oDone must match the oldest outstanding expectation
    always @(negedge iCLK) begin
        if (!iRST) begin
            if (oDone) begin
                if (sbQ.size() == 0) begin
                    checkOutput("unexpectedDone", 64'(oDone), 64'd0);
                end else begin
                    expT e;
                    e = sbQ.pop_front();
                    checkOutput("resultHiLo", {oHI, oLO}, {e.hi, e.lo});
                    checkOutput("divByZero", 64'(oDivByZero), 64'(e.dbz));
                    curHi = e.hi;
                    curLo = e.lo;
                end
            end else if (oDivByZero) begin
                checkOutput("dbzWithoutDone", 64'(oDivByZero), 64'd0);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int waited = 0;
        @(negedge iCLK);
        while (oBusy && waited < 100) begin
            @(negedge iCLK);
            waited++;
        end
        if (oBusy) failTimeout("issueWait");
        iStart = 1'b1;
        iOp    = op;
        iA     = a;
        iB     = b;
        if (op < 3'd4) sbQ.push_back(computeExpected(op, a, b));
        @(posedge iCLK);
        #1;
        iStart = 1'b0;
        iA     = $urandom;
        iB     = $urandom;
        if (op == 3'd4) begin
            checkOutput("mthi", 64'(oHI), 64'(a));
            curHi = a;
        end else if (op == 3'd5) begin
            checkOutput("mtlo", 64'(oLO), 64'(a));
            curLo = a;
        end else if (op >= 3'd6) begin
            checkOutput("nopHiLoBusy", {oHI, oLO, 31'd0, oBusy}, {curHi, curLo, 32'd0});
        end
    endtask

    task automatic drain();
        int waited = 0;
        while (sbQ.size() != 0 && waited < 200) begin
            @(negedge iCLK);
            waited++;
        end
        if (sbQ.size() != 0) failTimeout("drain");
    endtask

    task automatic waitDone(output int edges);
        edges = 0;
        while (edges < 100) begin
            @(posedge iCLK);
            #1;
            edges++;
            if (oDone) return;
        end
    endtask

    initial begin
        int          edges;
        int          stallCnt;
        logic [31:0] savedHi;
        logic [2:0]  op;
        logic [31:0] a, b;

        iRST = 1'b1; iStart = 1'b0; iOp = 3'd0; iA = 32'd0; iB = 32'd0; iReadReq = 1'b0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST = 1'b0;
        checkOutput("resetState", {oHI, oLO}, 64'd0);
        checkOutput("resetFlags", {61'd0, oBusy, oDone, oDivByZero}, 64'd0);

        applyStimulus(3'd0, 32'hFFFF_FFFD, 32'd7);
        waitDone(edges);
        checkOutput("multLatency", 64'(edges), 64'd33);
        checkOutput("multBusyAtDone", 64'(oBusy), 64'd0);
        drain();
        checkOutput("multNeg", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFEB);

        applyStimulus(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        checkOutput("multuMax", {oHI, oLO}, 64'hFFFF_FFFE_0000_0001);
        applyStimulus(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        drain();
        checkOutput("multMinusOnes", {oHI, oLO}, 64'h0000_0000_0000_0001);

        applyStimulus(3'd2, 32'hFFFF_FFF9, 32'd2);
        drain();
        checkOutput("divNeg", {oHI, oLO}, 64'hFFFF_FFFF_FFFF_FFFD);
        applyStimulus(3'd3, 32'd7, 32'd2);
        drain();
        checkOutput("divu", {oHI, oLO}, 64'h0000_0001_0000_0003);
        applyStimulus(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
        drain();
        checkOutput("divOverflow", {oHI, oLO}, 64'h0000_0000_8000_0000);

        applyStimulus(3'd3, 32'd7, 32'd0);
        checkOutput("dbzTiming", {61'd0, oDone, oDivByZero, oBusy}, 64'd6);
        drain();
        checkOutput("dbzValues", {oHI, oLO}, 64'h0000_0007_FFFF_FFFF);

        // Stall window, ignored issue while busy, and operand changes after start
        iReadReq = 1'b1;
        savedHi  = curHi;
        applyStimulus(3'd1, 32'd1234, 32'd5678);
        stallCnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge iCLK);
            if (oDone) break;
            if (oStall) stallCnt++;
            if (i == 5) begin
                iStart = 1'b1; iOp = 3'd4; iA = 32'd5;
            end else if (i == 6) begin
                iStart = 1'b0;
                checkOutput("mthiWhileBusy", 64'(oHI), 64'(savedHi));
            end
        end
        checkOutput("stallCycles", 64'(stallCnt), 64'd33);
        checkOutput("stallAtDone", {62'd0, oStall, oDone}, 64'd1);
        iReadReq = 1'b0;
        drain();

        applyStimulus(3'd6, 32'hDEAD_BEEF, 32'd1);
        applyStimulus(3'd7, 32'hDEAD_BEEF, 32'd1);

        // Reset partway through a divide must abort with no completion pulse
        applyStimulus(3'd2, 32'd1000, 32'd3);
        repeat (9) @(posedge iCLK);
        @(negedge iCLK);
        iRST = 1'b1;
        @(posedge iCLK);
        #1;
        iRST = 1'b0;
        sbQ.delete();
        curHi = 32'd0;
        curLo = 32'd0;
        checkOutput("abortHiLo", {oHI, oLO}, 64'd0);
        checkOutput("abortFlags", {62'd0, oBusy, oDone}, 64'd0);
        applyStimulus(3'd0, 32'd2, 32'd3);
        drain();
        checkOutput("postResetMult", 64'(oLO), 64'd6);

        // Randomized back-to-back traffic across all opcodes
        for (int n = 0; n < 40; n++) begin
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 9));
                2:       b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            applyStimulus(op, a, b);
        end
        drain();

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
